// File: rtl/des_dec_key_sched.sv
// -----------------------------------------------------------------------------
// des_dec_key_sched
//
// Sequential DES decryption key schedule. An accepted load runs the 64-bit key
// through PC-1 into the 28-bit C and D halves and emits K16 one cycle later.
// Each accepted subkey rotates C and D right by the round's shift, and PC-2 of
// the rotated halves becomes the next subkey. Subkeys therefore leave in the
// order K16..K1. Because the left-rotate schedule totals 28 bits of rotation,
// C16 equals C0, so K16 comes straight from the freshly loaded halves.
// Bit numbering follows DES: bit 1 is the MSB of every vector.
//
// Ports
//   clk           in   rising-edge clock
//   rst_n         in   synchronous active-low reset
//   load          in   start request, honoured only while idle
//   key_in[1:64]  in   DES key including parity bits 8,16,..,64
//   busy          out  schedule in progress
//   subkey[1:48]  out  current round subkey (PC-2 output)
//   subkey_valid  out  subkey/round_idx valid
//   subkey_ready  in   consumer accepts the subkey when valid & ready
//   round_idx     out  round number of subkey, 16..1; 0 when idle
//   done          out  one-cycle pulse after K1 is accepted
//   parity_err    out  key had a byte with even parity (PARITY_CHECK=1 only)
// -----------------------------------------------------------------------------
module des_dec_key_sched #(
    parameter bit PARITY_CHECK = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [1:64] key_in,
    output logic        busy,
    output logic [1:48] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [4:0]  round_idx,
    output logic        done,
    output logic        parity_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // PC-1: 64-bit key -> 56-bit C||D, dropping the parity bits.
    function automatic logic [1:56] pc1(input logic [1:64] k);
        return {k[57], k[49], k[41], k[33], k[25], k[17], k[9],
                k[1],  k[58], k[50], k[42], k[34], k[26], k[18],
                k[10], k[2],  k[59], k[51], k[43], k[35], k[27],
                k[19], k[11], k[3],  k[60], k[52], k[44], k[36],
                k[63], k[55], k[47], k[39], k[31], k[23], k[15],
                k[7],  k[62], k[54], k[46], k[38], k[30], k[22],
                k[14], k[6],  k[61], k[53], k[45], k[37], k[29],
                k[21], k[13], k[5],  k[28], k[20], k[12], k[4]};
    endfunction

    // PC-2: 56-bit C||D -> 48-bit round subkey.
    function automatic logic [1:48] pc2(input logic [1:56] cd);
        return {cd[14], cd[17], cd[11], cd[24], cd[1],  cd[5],
                cd[3],  cd[28], cd[15], cd[6],  cd[21], cd[10],
                cd[23], cd[19], cd[12], cd[4],  cd[26], cd[8],
                cd[16], cd[7],  cd[27], cd[20], cd[13], cd[2],
                cd[41], cd[52], cd[31], cd[37], cd[47], cd[55],
                cd[30], cd[40], cd[51], cd[45], cd[33], cd[48],
                cd[44], cd[49], cd[39], cd[56], cd[34], cd[53],
                cd[46], cd[42], cd[50], cd[36], cd[29], cd[32]};
    endfunction

    // Rotate a 28-bit half right (towards higher bit numbers) by 1 or 2.
    function automatic logic [1:28] rotr(input logic [1:28] v, input logic by_one);
        logic [1:28] r;
        if (by_one) begin
            r = {v[28], v[1:27]};
        end else begin
            r = {v[27:28], v[1:26]};
        end
        return r;
    endfunction

    // A DES key byte must have odd parity; flag any byte with even parity.
    function automatic logic key_parity_bad(input logic [1:64] k);
        return (~^k[1:8])   | (~^k[9:16])  | (~^k[17:24]) | (~^k[25:32]) |
               (~^k[33:40]) | (~^k[41:48]) | (~^k[49:56]) | (~^k[57:64]);
    endfunction

    state_t      state_q,  state_d;
    logic [1:28] c_q,      c_d;
    logic [1:28] d_q,      d_d;
    logic [1:48] subkey_q, subkey_d;
    logic [4:0]  round_q,  round_d;
    logic        valid_q,  valid_d;
    logic        busy_q,   busy_d;
    logic        done_q,   done_d;
    logic        perr_q,   perr_d;

    logic [1:56] cd_load_s;
    logic [1:28] c_rot_s;
    logic [1:28] d_rot_s;
    logic        shift_one_s;

    assign cd_load_s = pc1(key_in);
    // Rounds 16, 9 and 2 undo a single-bit left shift; all others undo two.
    assign shift_one_s = (round_q == 5'd16) || (round_q == 5'd9) || (round_q == 5'd2);
    assign c_rot_s = rotr(c_q, shift_one_s);
    assign d_rot_s = rotr(d_q, shift_one_s);

    // Next-state and next-output logic for the load/emit sequencer.
    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        d_d      = d_q;
        subkey_d = subkey_q;
        round_d  = round_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        perr_d   = perr_q;

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    c_d      = cd_load_s[1:28];
                    d_d      = cd_load_s[29:56];
                    subkey_d = pc2(cd_load_s);
                    round_d  = 5'd16;
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = ST_EMIT;
                    if (PARITY_CHECK) begin
                        perr_d = key_parity_bad(key_in);
                    end else begin
                        perr_d = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (valid_q && subkey_ready) begin
                    if (round_q == 5'd1) begin
                        // Last subkey taken: subkey keeps K1, everything else clears.
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        round_d = 5'd0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        c_d      = c_rot_s;
                        d_d      = d_rot_s;
                        subkey_d = pc2({c_rot_s, d_rot_s});
                        round_d  = round_q - 5'd1;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                round_d = 5'd0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            c_q      <= 28'd0;
            d_q      <= 28'd0;
            subkey_q <= 48'd0;
            round_q  <= 5'd0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            d_q      <= d_d;
            subkey_q <= subkey_d;
            round_q  <= round_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            perr_q   <= perr_d;
        end
    end

    assign busy         = busy_q;
    assign subkey       = subkey_q;
    assign subkey_valid = valid_q;
    assign round_idx    = round_q;
    assign done         = done_q;
    assign parity_err   = perr_q;

endmodule

// File: tb/tb_des_dec_key_sched.sv
// -----------------------------------------------------------------------------
// tb_des_dec_key_sched
//
// Drives des_dec_key_sched (PARITY_CHECK=1) through directed and random key
// schedules. Expected subkeys come from a forward (left-rotate) DES key
// schedule computed on plain integers; the DUT must emit them as K16..K1.
// -----------------------------------------------------------------------------
module tb_des_dec_key_sched;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [1:64] key_in;
    logic        busy;
    logic [1:48] subkey;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [4:0]  round_idx;
    logic        done;
    logic        parity_err;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    localparam logic [63:0] KEY_STD  = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_BADP = 64'h133457799BBCDFF0;
    localparam logic [63:0] KEY_ALT  = 64'h0E329232EA6D0D73;
    localparam logic [47:0] K16_STD  = 48'hCB3D8B0E17F5;
    localparam logic [47:0] K1_STD   = 48'h1B02EFFC7072;

    localparam int PC1 [56] = '{57, 49, 41, 33, 25, 17, 9,  1,  58, 50, 42, 34, 26, 18,
                                10, 2,  59, 51, 43, 35, 27, 19, 11, 3,  60, 52, 44, 36,
                                63, 55, 47, 39, 31, 23, 15, 7,  62, 54, 46, 38, 30, 22,
                                14, 6,  61, 53, 45, 37, 29, 21, 13, 5,  28, 20, 12, 4};
    localparam int PC2 [48] = '{14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10,
                                23, 19, 12, 4,  26, 8,  16, 7,  27, 20, 13, 2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    logic [47:0] exp_ks [17];
    logic        exp_perr;

    des_dec_key_sched #(.PARITY_CHECK(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load),
        .key_in       (key_in),
        .busy         (busy),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round_idx    (round_idx),
        .done         (done),
        .parity_err   (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Forward DES key schedule: K1..K16 by left rotation, plus byte parity.
    task automatic build_ref(input logic [63:0] key);
        logic [55:0] cd;
        logic [27:0] c;
        logic [27:0] d;
        logic [47:0] k;
        logic [63:0] t;
        int          s;
        for (int i = 0; i < 56; i++) cd[6'(55 - i)] = key[6'(64 - PC1[i])];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 1; r <= 16; r++) begin
            s = (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
            c = (c << s) | (c >> (28 - s));
            d = (d << s) | (d >> (28 - s));
            cd = {c, d};
            for (int j = 0; j < 48; j++) k[6'(47 - j)] = cd[6'(56 - PC2[j])];
            exp_ks[5'(r)] = k;
        end
        exp_perr = 1'b0;
        for (int b = 0; b < 8; b++) begin
            t = key >> (8 * b);
            if (^t[7:0] == 1'b0) exp_perr = 1'b1;
        end
    endtask

    // mode 0: plain run; 1: ignored load at round 10; 2: reset at round 8.
    task automatic run_sched(input logic [63:0] key, input int ready_pct,
                             input int mode, input bit std_consts);
        int r;
        int budget;
        bit rdy;
        build_ref(key);
        key_in = key;
        load   = 1'b1;
        @(posedge clk); #1;
        load   = 1'b0;
        key_in = {$urandom, $urandom};
        check("load_valid", 64'(subkey_valid), 64'd1);
        check("load_busy",  64'(busy),         64'd1);
        check("load_round", 64'(round_idx),    64'd16);
        check("load_k16",   64'(subkey),       64'(exp_ks[16]));
        check("load_done",  64'(done),         64'd0);
        check("load_perr",  64'(parity_err),   64'(exp_perr));
        if (std_consts) check("k16_const", 64'(subkey), 64'(K16_STD));
        r = 16;
        budget = 2000;
        while (r > 0 && budget > 0) begin
            rdy = ($urandom_range(99) < ready_pct);
            subkey_ready = rdy;
            if (mode == 1 && r == 10) begin
                load   = 1'b1;
                key_in = KEY_ALT;
            end else begin
                load = 1'b0;
            end
            if (mode == 2 && r == 8) rst_n = 1'b0;
            @(posedge clk); #1;
            load = 1'b0;
            if (mode == 2 && r == 8) begin
                rst_n = 1'b1;
                subkey_ready = 1'b0;
                check("rst_valid",  64'(subkey_valid), 64'd0);
                check("rst_busy",   64'(busy),         64'd0);
                check("rst_round",  64'(round_idx),    64'd0);
                check("rst_subkey", 64'(subkey),       64'd0);
                check("rst_done",   64'(done),         64'd0);
                check("rst_perr",   64'(parity_err),   64'd0);
                return;
            end
            if (rdy) r--;
            if (r > 0) begin
                check("emit_valid",  64'(subkey_valid), 64'd1);
                check("emit_busy",   64'(busy),         64'd1);
                check("emit_round",  64'(round_idx),    64'(r));
                check("emit_subkey", 64'(subkey),       64'(exp_ks[5'(r)]));
                check("emit_done",   64'(done),         64'd0);
            end
            budget--;
        end
        subkey_ready = 1'b0;
        check("sched_complete", 64'(r),            64'd0);
        check("end_done",       64'(done),         64'd1);
        check("end_valid",      64'(subkey_valid), 64'd0);
        check("end_busy",       64'(busy),         64'd0);
        check("end_round",      64'(round_idx),    64'd0);
        check("end_subkey",     64'(subkey),       64'(exp_ks[1]));
        check("end_perr",       64'(parity_err),   64'(exp_perr));
        if (std_consts) check("k1_const", 64'(subkey), 64'(K1_STD));
    endtask

    initial begin
        rst_n        = 1'b0;
        load         = 1'b0;
        key_in       = 64'd0;
        subkey_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid",  64'(subkey_valid), 64'd0);
        check("reset_busy",   64'(busy),         64'd0);
        check("reset_round",  64'(round_idx),    64'd0);
        check("reset_subkey", 64'(subkey),       64'd0);
        check("reset_done",   64'(done),         64'd0);
        check("reset_perr",   64'(parity_err),   64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_done", 64'(done), 64'd0);

        // Known key, ready held high.
        run_sched(KEY_STD, 100, 0, 1'b1);
        // Done cycle: following pulse clears and the next load is taken at once.
        run_sched(KEY_STD, 50, 0, 1'b1);
        // Load while busy must be ignored.
        run_sched(KEY_STD, 100, 1, 1'b1);
        // Reset mid-schedule, then restart.
        run_sched(KEY_STD, 100, 2, 1'b1);
        run_sched(KEY_STD, 100, 0, 1'b1);
        // Even-parity last byte: flagged, subkeys unchanged.
        run_sched(KEY_BADP, 100, 0, 1'b1);
        run_sched(KEY_STD, 100, 0, 1'b1);
        // Random keys with random backpressure.
        for (int n = 0; n < 1000; n++) begin
            run_sched({$urandom, $urandom}, 75, 0, 1'b0);
        end
        @(posedge clk); #1;
        check("final_done", 64'(done), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
